// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared definitions for the immediate generator.
//   - IMM_* format-select encodings seen on imm_src
//   - state_t: handshake FSM encodings (EMPTY / ONE / FULL)
//   - sign_ext(): widens a 32-bit immediate to 64 bits; callers keep the
//     low XLEN bits, so one helper serves both XLEN=32 and XLEN=64.
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    function automatic logic [63:0] sign_ext(input logic signed [31:0] val);
        logic signed [63:0] wide;
        wide = val;
        return wide;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational RISC-V immediate decoder.
// Shared with the single-cycle core path.
//   instr   in  32    raw instruction (bits [6:0] unused)
//   imm_src in  3     format select (I/S/B/U/J, Z when enabled)
//   imm     out XLEN  decoded immediate, zero for an illegal select
//   illegal out 1     imm_src is not a legal format
// Optional: define IMM_GEN_ZICSR_EN to accept imm_src=101 (CSR uimm,
// zero-extended instr[19:15]); otherwise 101 is illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [31:0] imm32;
    logic [63:0]        imm_wide;
    logic               unused_bits;

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
            // CSR uimm: top bit is zero so the later sign extension is a zero extension
            IMM_Z: imm32 = {27'b0, instr[19:15]};
`endif
            default: illegal = 1'b1;
        endcase
    end

    // All formats are 32-bit values sign-extended to XLEN (U included for RV64)
    assign imm_wide = sign_ext(imm32);
    assign imm      = imm_wide[XLEN-1:0];

    assign unused_bits = ^{instr[6:0], imm_wide};

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator between decode and execute.
// A beat accepted on in_* is decoded combinationally and registered into a
// main register (or a skid register when the output is stalled), so it is
// visible on out_* one cycle later. in_ready and out_valid are flops.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   instr, imm_src,in_tag input beat (tag is passed through untouched)
//   out_valid/out_ready   output handshake
//   imm_ext, out_tag      decoded immediate and its tag
//   out_illegal           beat had an illegal imm_src (imm_ext = 0)
//   illegal_cnt           saturating count of accepted illegal beats
// Optional: IMM_GEN_ZICSR_EN enables the Z (CSR uimm) format in imm_decode.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        imm_src,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm_ext,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

    state_t state, state_nxt;

    logic accept;
    logic emit;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    logic [XLEN-1:0]  imm_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             ill_p0;

    logic [XLEN-1:0]  skid_imm_p0;
    logic [TAG_W-1:0] skid_tag_p0;
    logic             skid_ill_p0;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !emit) begin
                    // Main is stalled: park the new beat behind it
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (emit && !accept) begin
                    state_nxt = EMPTY;
                end else if (accept && emit) begin
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (emit) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags are registered copies of the next state so that
    // neither depends combinationally on in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
        end
    end

    // Stage p0: main (output) register and skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_p0      <= '0;
            tag_p0      <= '0;
            ill_p0      <= 1'b0;
            skid_imm_p0 <= '0;
            skid_tag_p0 <= '0;
            skid_ill_p0 <= 1'b0;
        end else begin
            if (load_main_in) begin
                imm_p0 <= dec_imm;
                tag_p0 <= in_tag;
                ill_p0 <= dec_illegal;
            end else if (load_main_skid) begin
                imm_p0 <= skid_imm_p0;
                tag_p0 <= skid_tag_p0;
                ill_p0 <= skid_ill_p0;
            end
            if (load_skid) begin
                skid_imm_p0 <= dec_imm;
                skid_tag_p0 <= in_tag;
                skid_ill_p0 <= dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal) begin
            illegal_cnt <= sat_inc(illegal_cnt);
        end
    end

    assign imm_ext     = imm_p0;
    assign out_tag     = tag_p0;
    assign out_illegal = ill_p0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance share the same stimulus and are compared
// against a FIFO scoreboard plus directed literal values.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_illegal;
    logic [31:0] imm_ext;
    logic [4:0]  out_tag;
    logic [15:0] illegal_cnt;

    logic        in_ready_w, out_valid_w, out_illegal_w;
    logic [63:0] imm_ext_w;
    logic [4:0]  out_tag_w;
    logic [1:0]  illegal_cnt_w;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .imm_ext(imm_ext),
        .out_tag(out_tag), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid_w), .out_ready(out_ready), .imm_ext(imm_ext_w),
        .out_tag(out_tag_w), .out_illegal(out_illegal_w), .illegal_cnt(illegal_cnt_w)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } beat_t;

    beat_t q[$];
    int    cnt_m;
    int    nvec = 0;
    int    nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each format is a signed field of a given width; value widened to 64 bits
    function automatic beat_t ref_beat(input logic [31:0] ins, input logic [2:0] src,
                                       input logic [4:0] tg);
        beat_t b;
        logic signed [11:0] f12;
        logic signed [12:0] f13;
        logic signed [31:0] f32;
        logic signed [20:0] f21;
        b.tag = tg;
        b.ill = 1'b0;
        b.imm = '0;
        case (src)
            3'd0: begin f12 = ins[31:20];                    b.imm = longint'(f12); end
            3'd1: begin f12 = {ins[31:25], ins[11:7]};       b.imm = longint'(f12); end
            3'd2: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                        b.imm = longint'(f13); end
            3'd3: begin f32 = {ins[31:12], 12'h000};         b.imm = longint'(f32); end
            3'd4: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                        b.imm = longint'(f21); end
`ifdef IMM_GEN_ZICSR_EN
            3'd5: b.imm = {59'd0, ins[19:15]};
`endif
            default: b.ill = 1'b1;
        endcase
        return b;
    endfunction

    task automatic check_all();
        int cm;
        cm = (cnt_m > 65535) ? 65535 : cnt_m;
        check("in_ready",    {63'd0, in_ready},    {63'd0, q.size() < 2});
        check("out_valid",   {63'd0, out_valid},   {63'd0, q.size() > 0});
        check("in_ready64",  {63'd0, in_ready_w},  {63'd0, q.size() < 2});
        check("out_valid64", {63'd0, out_valid_w}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("imm32",   {32'd0, imm_ext},     {32'd0, q[0].imm[31:0]});
            check("tag",     {59'd0, out_tag},     {59'd0, q[0].tag});
            check("ill",     {63'd0, out_illegal}, {63'd0, q[0].ill});
            check("imm64",   imm_ext_w,            q[0].imm);
            check("tag64",   {59'd0, out_tag_w},   {59'd0, q[0].tag});
            check("ill64",   {63'd0, out_illegal_w}, {63'd0, q[0].ill});
        end
        check("cnt16", {48'd0, illegal_cnt},   64'(cm));
        check("cnt2",  {62'd0, illegal_cnt_w}, 64'((cnt_m > 3) ? 3 : cnt_m));
    endtask

    // Drive one cycle from a negedge, update the model at the posedge,
    // then check at the following negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [4:0] tg, input logic ordy);
        logic acc, em;
        beat_t b;
        in_valid  = v;
        instr     = ins;
        imm_src   = src;
        in_tag    = tg;
        out_ready = ordy;
        acc = v && (q.size() < 2);
        em  = ordy && (q.size() > 0);
        b   = ref_beat(ins, src, tg);
        @(posedge clk);
        if (em) void'(q.pop_front());
        if (acc) begin
            q.push_back(b);
            if (b.ill) cnt_m++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        q.delete();
        cnt_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 3'd0, 5'd0, 1'b1);
    endtask

    logic [31:0] d_instr [4] = '{32'hFE112E23, 32'hFE000EE3, 32'h12345037, 32'h0080006F};
    logic [2:0]  d_src   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] d_exp   [4] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};

    initial begin
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        cnt_m     = 0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_valid", {63'd0, out_valid},   64'd0);
        check("rst in_ready",  {63'd0, in_ready},    64'd1);
        check("rst imm",       {32'd0, imm_ext},     64'd0);
        check("rst tag",       {59'd0, out_tag},     64'd0);
        check("rst ill",       {63'd0, out_illegal}, 64'd0);
        check("rst cnt",       {48'd0, illegal_cnt}, 64'd0);
        rst_n = 1'b1;

        // Single I-format beat, 1-cycle latency
        cycle(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1);
        check("I vld",   {63'd0, out_valid}, 64'd1);
        check("I imm",   {32'd0, imm_ext},   64'h0000_0000_FFFF_FFFF);
        check("I imm64", imm_ext_w,          64'hFFFF_FFFF_FFFF_FFFF);
        check("I ill",   {63'd0, out_illegal}, 64'd0);

        // Remaining formats back to back
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, d_instr[i], d_src[i], 5'(i + 2), 1'b1);
            check("fmt imm", {32'd0, imm_ext}, {32'd0, d_exp[i]});
        end
        drain();

        // Backpressure: fill both registers, third beat must be held off
        cycle(1'b1, 32'h00100093, 3'd0, 5'd1, 1'b0);
        cycle(1'b1, 32'h00200093, 3'd0, 5'd2, 1'b0);
        check("bp full in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b0);
        check("bp hold tag", {59'd0, out_tag}, 64'd1);
        cycle(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b1);
        check("bp tag2", {59'd0, out_tag}, 64'd2);
        cycle(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b1);
        check("bp tag3", {59'd0, out_tag}, 64'd3);
        drain();

        // Streaming: accept+emit every cycle
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, $urandom, 3'($urandom_range(0, 4)), 5'(i), 1'b1);
            check("stream in_ready", {63'd0, in_ready}, 64'd1);
        end
        drain();

        // Illegal selects and counter saturation
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 3'd7, 5'(i), 1'b1);
        check("ill3 cnt16", {48'd0, illegal_cnt},   64'd3);
        check("ill3 cnt2",  {62'd0, illegal_cnt_w}, 64'd3);
        check("ill imm",    {32'd0, imm_ext},       64'd0);
        check("ill flag",   {63'd0, out_illegal},   64'd1);
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 3'd6, 5'(i), 1'b1);
        check("ill5 cnt16", {48'd0, illegal_cnt},   64'd5);
        check("ill5 cnt2 sat", {62'd0, illegal_cnt_w}, 64'd3);

        // Z format
        cycle(1'b1, 32'h0001D073, 3'd5, 5'd9, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
        check("Z imm", {32'd0, imm_ext},     64'd3);
        check("Z ill", {63'd0, out_illegal}, 64'd0);
`else
        check("Z imm", {32'd0, imm_ext},     64'd0);
        check("Z ill", {63'd0, out_illegal}, 64'd1);
`endif
        drain();

        // Asynchronous reset while FULL
        cycle(1'b1, 32'h00100093, 3'd7, 5'd1, 1'b0);
        cycle(1'b1, 32'h00200093, 3'd0, 5'd2, 1'b0);
        check("pre-rst in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst out_valid", {63'd0, out_valid},   64'd0);
        check("arst in_ready",  {63'd0, in_ready},    64'd1);
        check("arst cnt",       {48'd0, illegal_cnt}, 64'd0);
        check("arst cnt2",      {62'd0, illegal_cnt_w}, 64'd0);
        q.delete();
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                  5'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
